// File: rtl/router_out_fifo.sv
// Per-destination output buffer of the 1x3 router.
// Buffers the register-stage byte stream with a header tag bit, drains it to one
// destination port, and tracks packet boundaries from the header length field.
module router_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             soft_reset,
  input  logic             write_enb,
  input  logic             lfd_state,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_enb,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             pkt_busy,
  output logic             pkt_done,
  output logic             protocol_err
);

  // Byte counter holds the 6-bit length field plus one for the parity byte.
  localparam int unsigned CW = WIDTH - 1;
  localparam int unsigned EW = WIDTH + 1;

  logic [EW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [CW-1:0] cnt;

  logic          wr_acc;
  logic          rd_acc;
  logic          clr;
  logic [EW-1:0] rd_entry;
  logic          rd_hdr;

  // Occupancy flags from the registered pointers.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pkt_busy = (cnt != '0);

  // Request qualification on start-of-cycle flags, and the head entry.
  always_comb begin
    clr      = !resetn || soft_reset;
    wr_acc   = write_enb && !full;
    rd_acc   = read_enb && !empty;
    rd_entry = mem[rd_ptr[AW-1:0]];
    rd_hdr   = rd_entry[WIDTH];
  end

  // Storage array; contents are left alone on reset since pointers make them unreachable.
  always_ff @(posedge clk) begin
    if (!clr && wr_acc) begin
      mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
    end
  end

  // Write and read pointers, wrapping modulo 2*DEPTH.
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_acc) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Registered read data with one-cycle latency; holds when no read is accepted.
  always_ff @(posedge clk) begin
    if (clr) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= rd_entry[WIDTH-1:0];
    end
  end

  // Packet byte counter, end-of-packet pulse and sticky protocol error.
  always_ff @(posedge clk) begin
    if (clr) begin
      cnt          <= '0;
      pkt_done     <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      pkt_done <= 1'b0;
      if (rd_acc) begin
        if (rd_hdr) begin
          // A new header always reloads, abandoning any open packet silently.
          cnt <= CW'(rd_entry[WIDTH-1:2]) + CW'(1);
        end else if (cnt != '0) begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) pkt_done <= 1'b1;
        end else begin
          protocol_err <= 1'b1;
        end
      end
    end
  end

endmodule
